// File: rtl/ref_pulse_gen.sv
// Reference pulse generator: launches a REF pulse every PERIOD cycles, then waits for the
// far-end counter to return an ACK pulse (or for a timeout) before launching the next one.
module ref_pulse_gen #(
    parameter int PERIOD_W = 16,
    parameter int TMO_CYC  = 255
) (
    input  logic                MCLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic [PERIOD_W-1:0] PERIOD,
    input  logic [3:0]          WIDTH,
    input  logic                ACK,
    input  logic                CLR,
    output logic                REF,
    output logic                BUSY,
    output logic [PERIOD_W-1:0] SENT_COUNT,
    output logic                TIMEOUT,
    output logic [1:0]          DBG_STATE
);

    // One spare bit keeps the width legal even for TMO_CYC = 0.
    localparam int TMO_W = $clog2(TMO_CYC + 2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT    = 2'd1,
        S_PULSE    = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [PERIOD_W-1:0] pcnt, pcnt_n, reload;
    logic [3:0]          wcnt, wcnt_n;
    logic [TMO_W-1:0]    tcnt, tcnt_n;
    logic                ack_s1, ack_s2, ack_s3;
    logic                ack_ev;
    logic                ack_hit, tmo_hit;

    // ACK is asynchronous: two flops for metastability, a third to find the rising edge.
    assign ack_ev    = ack_s2 & ~ack_s3;
    assign reload    = (PERIOD < PERIOD_W'(2)) ? PERIOD_W'(1) : PERIOD - PERIOD_W'(1);
    assign BUSY      = (state != S_IDLE);
    assign DBG_STATE = state;

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        wcnt_n  = wcnt;
        tcnt_n  = tcnt;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (EN) begin
                    pcnt_n  = reload;
                    state_n = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!EN) begin
                    state_n = S_IDLE;
                end else if (pcnt == '0) begin
                    wcnt_n  = WIDTH;
                    state_n = S_PULSE;
                end else begin
                    pcnt_n = pcnt - PERIOD_W'(1);
                end
            end
            S_PULSE: begin
                if (wcnt == '0) begin
                    tcnt_n  = TMO_W'(TMO_CYC);
                    state_n = S_WAIT_ACK;
                end else begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            S_WAIT_ACK: begin
                // An ACK arriving on the expiry cycle still counts as a good return.
                if (ack_ev || (tcnt == '0)) begin
                    ack_hit = ack_ev;
                    tmo_hit = ~ack_ev;
                    if (EN) begin
                        pcnt_n  = reload;
                        state_n = S_COUNT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    tcnt_n = tcnt - TMO_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            pcnt       <= '0;
            wcnt       <= '0;
            tcnt       <= '0;
            ack_s1     <= 1'b0;
            ack_s2     <= 1'b0;
            ack_s3     <= 1'b0;
            REF        <= 1'b0;
            SENT_COUNT <= '0;
            TIMEOUT    <= 1'b0;
        end else begin
            state  <= state_n;
            pcnt   <= pcnt_n;
            wcnt   <= wcnt_n;
            tcnt   <= tcnt_n;
            ack_s1 <= ACK;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
            REF    <= (state_n == S_PULSE);
            if (CLR) begin
                SENT_COUNT <= '0;
            end else if (ack_hit) begin
                SENT_COUNT <= SENT_COUNT + PERIOD_W'(1);
            end
            // A timeout on the same edge as CLR must not be lost.
            if (tmo_hit) begin
                TIMEOUT <= 1'b1;
            end else if (CLR) begin
                TIMEOUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ref_pulse_gen.sv
// Directed bench for ref_pulse_gen: expected values are queued as each step is driven
// and popped when the DUT output is sampled, 1 time unit after the rising edge.
module tb_ref_pulse_gen;

    localparam int PW = 4;

    logic          MCLK;
    logic          RST_N;
    logic          EN;
    logic [PW-1:0] PERIOD;
    logic [3:0]    WIDTH;
    logic          ACK;
    logic          CLR;
    logic          REF;
    logic          BUSY;
    logic [PW-1:0] SENT_COUNT;
    logic          TIMEOUT;
    logic [1:0]    DBG_STATE;

    logic [31:0] exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    ref_pulse_gen #(.PERIOD_W(PW), .TMO_CYC(255)) dut (
        .MCLK       (MCLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .PERIOD     (PERIOD),
        .WIDTH      (WIDTH),
        .ACK        (ACK),
        .CLR        (CLR),
        .REF        (REF),
        .BUSY       (BUSY),
        .SENT_COUNT (SENT_COUNT),
        .TIMEOUT    (TIMEOUT),
        .DBG_STATE  (DBG_STATE)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Ticks until REF is seen high; returns the bound if it never rises.
    task automatic wait_ref_rise(output int n);
        n = 0;
        while (n < 40) begin
            tick(1);
            n++;
            if (REF) break;
        end
    endtask

    // Called with REF high; counts sampled cycles of REF high, ends just after it falls.
    task automatic measure_high(output int h);
        h = 0;
        while (REF && h < 40) begin
            h++;
            tick(1);
        end
    endtask

    // ACK rises now; the synchronized event is consumed on the third edge.
    task automatic send_ack(input logic clr_on_event);
        ACK = 1'b1;
        tick(2);
        CLR = clr_on_event;
        tick(1);
        CLR = 1'b0;
        ACK = 1'b0;
    endtask

    initial begin
        int n;
        int h;
        int seen;

        RST_N = 1'b0; EN = 1'b0; PERIOD = 4'd10; WIDTH = 4'd2; ACK = 1'b0; CLR = 1'b0;
        tick(3);

        // Reset state
        expect_val(0); check("rst_ref", REF);
        expect_val(0); check("rst_busy", BUSY);
        expect_val(0); check("rst_sent", SENT_COUNT);
        expect_val(0); check("rst_timeout", TIMEOUT);
        expect_val(0); check("rst_state", DBG_STATE);
        RST_N = 1'b1;
        tick(1);

        // PERIOD=10, WIDTH=2: launch edge plus 10 edges, 3-cycle pulse, ACK, relaunch
        EN = 1'b1;
        expect_val(11); wait_ref_rise(n); check("p10_first_rise", n);
        expect_val(3);  measure_high(h);  check("p10_high", h);
        expect_val(1);  check("p10_busy_wait", BUSY);
        tick(4);
        send_ack(1'b0);
        expect_val(1);  check("p10_sent", SENT_COUNT);
        expect_val(10); wait_ref_rise(n); check("p10_rerise", n);
        expect_val(3);  measure_high(h);  check("p10_high2", h);

        // No ACK: TIMEOUT exactly 256 edges after REF falls, then the next pulse follows
        tick(255);
        expect_val(0);  check("tmo_early", TIMEOUT);
        tick(1);
        expect_val(1);  check("tmo_set", TIMEOUT);
        expect_val(1);  check("tmo_sent_kept", SENT_COUNT);
        expect_val(10); wait_ref_rise(n); check("tmo_next_rise", n);
        measure_high(h);

        // CLR while waiting, then a normal ACK
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        expect_val(0); check("clr_timeout", TIMEOUT);
        expect_val(0); check("clr_sent", SENT_COUNT);
        send_ack(1'b0);
        expect_val(1); check("clr_then_ack", SENT_COUNT);

        // EN dropped in COUNT: IDLE next edge, no pulse
        tick(3);
        EN = 1'b0;
        tick(1);
        expect_val(0); check("en_drop_count_state", DBG_STATE);
        expect_val(0); check("en_drop_count_busy", BUSY);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (REF) seen = 1;
        end
        expect_val(0); check("en_drop_count_noref", seen);

        // PERIOD=0 behaves as 2; ACK with EN=0 goes to IDLE
        PERIOD = 4'd0; WIDTH = 4'd2; EN = 1'b1;
        expect_val(3); wait_ref_rise(n); check("p0_rise", n);
        expect_val(3); measure_high(h);  check("p0_high", h);
        EN = 1'b0;
        send_ack(1'b0);
        expect_val(0); check("ack_en0_idle", DBG_STATE);
        expect_val(2); check("p0_sent", SENT_COUNT);

        // PERIOD=1 behaves as 2; EN dropped in PULSE keeps the full 5-cycle pulse
        PERIOD = 4'd1; WIDTH = 4'd4; EN = 1'b1;
        expect_val(3); wait_ref_rise(n); check("p1_rise", n);
        EN = 1'b0;
        expect_val(5); measure_high(h);  check("en_drop_pulse_high", h);
        expect_val(3); check("en_drop_pulse_wait", DBG_STATE);
        tick(2);
        send_ack(1'b0);
        expect_val(0); check("en_drop_pulse_idle", BUSY);
        expect_val(3); check("en_drop_pulse_sent", SENT_COUNT);

        // ACK event on the exact expiry edge: count, no TIMEOUT
        PERIOD = 4'd2; WIDTH = 4'd0; EN = 1'b1;
        expect_val(3); wait_ref_rise(n); check("coinc_rise", n);
        EN = 1'b0;
        expect_val(1); measure_high(h);  check("coinc_high", h);
        tick(253);
        send_ack(1'b0);
        expect_val(0); check("coinc_timeout", TIMEOUT);
        expect_val(4); check("coinc_sent", SENT_COUNT);
        expect_val(0); check("coinc_idle", DBG_STATE);

        // Run up to all-ones, then one more ACK wraps to 0
        EN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            expect_val(i == 0 ? 3 : 2);
            wait_ref_rise(n);
            check("wrap_rise", n);
            measure_high(h);
            tick($urandom_range(0, 6));
            send_ack(1'b0);
            if (i == 10) begin
                expect_val(15); check("wrap_all_ones", SENT_COUNT);
            end
        end
        expect_val(0); check("wrap_zero", SENT_COUNT);
        expect_val(0); check("wrap_no_timeout", TIMEOUT);

        // CLR coinciding with an increment leaves 0
        wait_ref_rise(n);
        measure_high(h);
        send_ack(1'b0);
        expect_val(1); check("pre_clr_inc", SENT_COUNT);
        wait_ref_rise(n);
        measure_high(h);
        send_ack(1'b1);
        expect_val(0); check("clr_beats_inc", SENT_COUNT);

        // Timeout coinciding with CLR: set beats clear
        wait_ref_rise(n);
        measure_high(h);
        tick(255);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        expect_val(1); check("tmo_beats_clr", TIMEOUT);

        // Reset mid-PULSE, with ACK activity across reset release
        WIDTH = 4'd8;
        expect_val(2); wait_ref_rise(n); check("rst_pulse_rise", n);
        tick(2);
        RST_N = 1'b0;
        tick(1);
        expect_val(0); check("midrst_ref", REF);
        expect_val(0); check("midrst_busy", BUSY);
        expect_val(0); check("midrst_timeout", TIMEOUT);
        expect_val(0); check("midrst_sent", SENT_COUNT);
        EN = 1'b0;
        ACK = 1'b1;
        tick(2);
        RST_N = 1'b1;
        tick(1);
        ACK = 1'b0;
        tick(6);
        expect_val(0); check("ack_in_rst_sent", SENT_COUNT);
        expect_val(0); check("ack_in_rst_state", DBG_STATE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
